// File: rtl/core_control_fsm.sv
// Multi-cycle core control FSM: fetch / execute / memory sequencing plus debug-module
// halt, resume, abstract-command and program-buffer handling.
module core_control_fsm #(
    parameter bit RESET_HALTED = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] f3,
    input  logic       mem_complete,
    input  logic       cond,
    input  logic       halt_req,
    input  logic       resume_req,
    input  logic       abs_req,
    input  logic       abs_write,
    input  logic       progbuf_req,
    output logic       halted,
    output logic       write_pc_ne,
    output logic       write_pc_ex,
    output logic       write_pc,
    output logic       write_ir,
    output logic       write_rd,
    output logic       write_csr,
    output logic       mem_read,
    output logic       mem_write,
    output logic       addr_sel,
    output logic       abstract_write,
    output logic       abstract_done,
    output logic       progbuf,
    output logic [1:0] rd_sel,
    output logic [1:0] alu_insel1,
    output logic [1:0] alu_insel2
);

    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpMisc   = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam logic       AddrAlu = 1'b0;
    localparam logic       AddrPc  = 1'b1;
    localparam logic [1:0] RdAlu   = 2'b00;
    localparam logic [1:0] RdMem   = 2'b01;
    localparam logic [1:0] RdCsr   = 2'b10;
    localparam logic [1:0] In1Rs   = 2'b00;
    localparam logic [1:0] In1Pc   = 2'b01;
    localparam logic [1:0] In1Zr   = 2'b10;
    localparam logic [1:0] In2Rs   = 2'b00;
    localparam logic [1:0] In2Im   = 2'b01;
    localparam logic [1:0] In2Is   = 2'b10;

    typedef enum logic [2:0] {
        StFetch,
        StExec,
        StMem,
        StHalted,
        StAbstract
    } state_e;

    state_e state_q, state_d;
    state_e fetch_entry;
    logic   pb_q, pb_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_HALTED ? StHalted : StFetch;
            pb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pb_q    <= pb_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pb_d           = pb_q;
        // halt_req is only honoured at instruction boundaries, and not inside a progbuf run
        fetch_entry    = (halt_req && !pb_q) ? StHalted : StFetch;
        halted         = 1'b0;
        write_pc_ne    = 1'b0;
        write_pc_ex    = 1'b0;
        write_ir       = 1'b0;
        write_rd       = 1'b0;
        write_csr      = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        addr_sel       = AddrAlu;
        abstract_write = 1'b0;
        abstract_done  = 1'b0;
        progbuf        = pb_q;
        rd_sel         = RdAlu;
        alu_insel1     = In1Rs;
        alu_insel2     = In2Rs;

        case (state_q)
            StFetch: begin
                addr_sel = AddrPc;
                mem_read = 1'b1;
                if (mem_complete) begin
                    write_ir = 1'b1;
                    state_d  = StExec;
                end
            end
            StExec: begin
                state_d = fetch_entry;
                case (opcode)
                    OpOp: begin
                        write_rd    = 1'b1;
                        write_pc_ne = 1'b1;
                    end
                    OpImm: begin
                        alu_insel2  = (f3 == 3'b001 || f3 == 3'b101) ? In2Is : In2Im;
                        write_rd    = 1'b1;
                        write_pc_ne = 1'b1;
                    end
                    OpLui, OpAuipc: begin
                        alu_insel1  = (opcode == OpLui) ? In1Zr : In1Pc;
                        alu_insel2  = In2Im;
                        write_rd    = 1'b1;
                        write_pc_ne = 1'b1;
                    end
                    OpJal, OpJalr: begin
                        alu_insel1  = (opcode == OpJal) ? In1Pc : In1Rs;
                        alu_insel2  = In2Im;
                        write_rd    = 1'b1;
                        write_pc_ex = 1'b1;
                    end
                    OpBranch: begin
                        alu_insel1  = In1Pc;
                        alu_insel2  = In2Im;
                        write_pc_ex = cond;
                        write_pc_ne = !cond;
                    end
                    OpLoad, OpStore: state_d = StMem;
                    OpMisc:          write_pc_ne = 1'b1;
                    OpSystem: begin
                        if (f3 != 3'b000) begin
                            write_csr   = 1'b1;
                            write_rd    = 1'b1;
                            rd_sel      = RdCsr;
                            alu_insel1  = f3[2] ? In1Zr : In1Rs;
                            alu_insel2  = In2Im;
                            write_pc_ne = 1'b1;
                        end else begin
                            state_d       = StHalted;
                            abstract_done = pb_q;
                            pb_d          = 1'b0;
                        end
                    end
                    default: begin
                        state_d       = StHalted;
                        abstract_done = pb_q;
                        pb_d          = 1'b0;
                    end
                endcase
            end
            StMem: begin
                alu_insel2 = In2Im;
                addr_sel   = AddrAlu;
                mem_write  = (opcode == OpStore);
                mem_read   = (opcode != OpStore);
                if (mem_complete) begin
                    write_pc_ne = 1'b1;
                    if (opcode != OpStore) begin
                        write_rd = 1'b1;
                        rd_sel   = RdMem;
                    end
                    state_d = fetch_entry;
                end
            end
            StHalted: begin
                halted = 1'b1;
                if (resume_req) begin
                    state_d = StFetch;
                end else if (abs_req) begin
                    state_d = StAbstract;
                end else if (progbuf_req) begin
                    state_d = StFetch;
                    pb_d    = 1'b1;
                end
            end
            StAbstract: begin
                halted         = 1'b1;
                abstract_write = abs_write;
                abstract_done  = 1'b1;
                state_d        = StHalted;
            end
            default: state_d = StFetch;
        endcase

        if (rst) begin
            halted         = 1'b0;
            write_pc_ne    = 1'b0;
            write_pc_ex    = 1'b0;
            write_ir       = 1'b0;
            write_rd       = 1'b0;
            write_csr      = 1'b0;
            mem_read       = 1'b0;
            mem_write      = 1'b0;
            addr_sel       = 1'b0;
            abstract_write = 1'b0;
            abstract_done  = 1'b0;
            progbuf        = 1'b0;
            rd_sel         = 2'b00;
            alu_insel1     = 2'b00;
            alu_insel2     = 2'b00;
        end
    end

    assign write_pc = write_pc_ne | write_pc_ex;

endmodule

// File: tb/tb_core_control_fsm.sv
// Self-checking bench for core_control_fsm: directed debug scenarios plus a randomized
// instruction stream checked against an instruction-level reference model.
module tb_core_control_fsm;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int N_FETCH = 0;
    localparam int N_MEM   = 1;
    localparam int N_HALT  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, mem_complete, cond, halt_req, resume_req, abs_req, abs_write, progbuf_req;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic       halted, write_pc_ne, write_pc_ex, write_pc, write_ir, write_rd, write_csr;
    logic       mem_read, mem_write, addr_sel, abstract_write, abstract_done, progbuf;
    logic [1:0] rd_sel, alu_insel1, alu_insel2;

    core_control_fsm #(.RESET_HALTED(1'b0)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .f3(f3), .mem_complete(mem_complete),
        .cond(cond), .halt_req(halt_req), .resume_req(resume_req), .abs_req(abs_req),
        .abs_write(abs_write), .progbuf_req(progbuf_req), .halted(halted),
        .write_pc_ne(write_pc_ne), .write_pc_ex(write_pc_ex), .write_pc(write_pc),
        .write_ir(write_ir), .write_rd(write_rd), .write_csr(write_csr),
        .mem_read(mem_read), .mem_write(mem_write), .addr_sel(addr_sel),
        .abstract_write(abstract_write), .abstract_done(abstract_done), .progbuf(progbuf),
        .rd_sel(rd_sel), .alu_insel1(alu_insel1), .alu_insel2(alu_insel2)
    );

    int   checks = 0;
    int   failures = 0;
    logic pb_mode = 1'b0;
    logic e_halted, e_ne, e_ex, e_ir, e_rd, e_csr, e_mrd, e_mwr, e_addr, e_aw, e_ad, e_pb;
    logic [1:0] e_rdsel, e_in1, e_in2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_exp();
        {e_halted, e_ne, e_ex, e_ir, e_rd, e_csr, e_mrd, e_mwr, e_addr, e_aw, e_ad} = '0;
        e_pb = pb_mode;
        e_rdsel = 2'b00;
        e_in1 = 2'b00;
        e_in2 = 2'b00;
    endtask

    task automatic check(input string tag);
        logic [18:0] got, want;
        got  = {halted, write_pc_ne, write_pc_ex, write_pc, write_ir, write_rd, write_csr,
                mem_read, mem_write, addr_sel, abstract_write, abstract_done, progbuf,
                rd_sel, alu_insel1, alu_insel2};
        want = {e_halted, e_ne, e_ex, e_ne | e_ex, e_ir, e_rd, e_csr, e_mrd, e_mwr, e_addr,
                e_aw, e_ad, e_pb, e_rdsel, e_in1, e_in2};
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, want);
        end
    endtask

    // Instruction-level reference: what one EXEC cycle must show for a given instruction.
    task automatic model_exec(input logic [6:0] op, input logic [2:0] fn3, input logic c,
                              output int nxt);
        nxt = N_FETCH;
        case (op)
            OP_OP:     begin e_rd = 1; e_ne = 1; end
            OP_IMM:    begin
                e_in2 = (fn3 == 3'b001 || fn3 == 3'b101) ? 2'b10 : 2'b01;
                e_rd = 1; e_ne = 1;
            end
            OP_LUI:    begin e_in1 = 2'b10; e_in2 = 2'b01; e_rd = 1; e_ne = 1; end
            OP_AUIPC:  begin e_in1 = 2'b01; e_in2 = 2'b01; e_rd = 1; e_ne = 1; end
            OP_JAL:    begin e_in1 = 2'b01; e_in2 = 2'b01; e_rd = 1; e_ex = 1; end
            OP_JALR:   begin e_in2 = 2'b01; e_rd = 1; e_ex = 1; end
            OP_BRANCH: begin e_in1 = 2'b01; e_in2 = 2'b01; e_ex = c; e_ne = !c; end
            OP_LOAD, OP_STORE: nxt = N_MEM;
            OP_MISC:   e_ne = 1;
            OP_SYSTEM: begin
                if (fn3 != 3'b000) begin
                    e_csr = 1; e_rd = 1; e_rdsel = 2'b10; e_ne = 1; e_in2 = 2'b01;
                    e_in1 = (fn3 >= 3'd4) ? 2'b10 : 2'b00;
                end else begin
                    nxt = N_HALT;
                end
            end
            default:   nxt = N_HALT;
        endcase
        if (nxt == N_HALT) e_ad = pb_mode;
    endtask

    task automatic fetch_phase(input int waits);
        for (int i = 0; i < waits; i++) begin
            mem_complete = 1'b0;
            #1; clr_exp(); e_mrd = 1; e_addr = 1; check("fetch_wait");
            tick();
        end
        mem_complete = 1'b1;
        #1; clr_exp(); e_mrd = 1; e_addr = 1; e_ir = 1; check("fetch_done");
        tick();
        mem_complete = 1'b0;
    endtask

    task automatic exec_phase(input logic [6:0] op, input logic [2:0] fn3, input logic c,
                              output int nxt);
        opcode = op; f3 = fn3; cond = c;
        mem_complete = 1'($urandom_range(0, 1));
        #1; clr_exp(); model_exec(op, fn3, c, nxt); check("exec");
        tick();
        mem_complete = 1'b0;
        if (nxt == N_HALT) pb_mode = 1'b0;
    endtask

    task automatic mem_phase(input logic is_store, input int waits);
        for (int i = 0; i <= waits; i++) begin
            mem_complete = (i == waits);
            #1; clr_exp();
            e_in2 = 2'b01; e_mrd = !is_store; e_mwr = is_store;
            if (i == waits) begin
                e_ne = 1;
                if (!is_store) begin e_rd = 1; e_rdsel = 2'b01; end
            end
            check(i == waits ? "mem_done" : "mem_wait");
            tick();
        end
        mem_complete = 1'b0;
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] fn3, input logic c,
                             input int fw, input int mw, output int nxt);
        fetch_phase(fw);
        exec_phase(op, fn3, c, nxt);
        if (nxt == N_MEM) begin
            mem_phase(op == OP_STORE, mw);
            nxt = N_FETCH;
        end
        if (nxt == N_FETCH && halt_req && !pb_mode) nxt = N_HALT;
    endtask

    task automatic halted_cycle(input string tag);
        #1; clr_exp(); e_halted = 1; check(tag);
        tick();
    endtask

    task automatic pick_legal(output logic [6:0] op, output logic [2:0] fn3);
        fn3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 10))
            0: op = OP_OP;     1: op = OP_IMM;    2: op = OP_LUI;  3: op = OP_AUIPC;
            4: op = OP_JAL;    5: op = OP_JALR;   6: op = OP_BRANCH;
            7: op = OP_LOAD;   8: op = OP_STORE;  9: op = OP_MISC;
            default: begin op = OP_SYSTEM; fn3 = 3'($urandom_range(1, 7)); end
        endcase
    endtask

    task automatic random_run(input int n);
        logic [6:0] op;
        logic [2:0] fn3;
        int nxt;
        for (int k = 0; k < n; k++) begin
            pick_legal(op, fn3);
            run_instr(op, fn3, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                      $urandom_range(0, 3), nxt);
        end
    endtask

    initial begin
        int nxt;
        logic [6:0] bad_op;
        // Reset with every input active: outputs must stay quiet.
        rst = 1; opcode = OP_LOAD; f3 = 3'b000; mem_complete = 1; cond = 1; halt_req = 1;
        resume_req = 1; abs_req = 1; abs_write = 1; progbuf_req = 1;
        repeat (3) begin
            tick(); clr_exp(); check("reset_zero");
        end
        rst = 0; mem_complete = 0; cond = 0; halt_req = 0; resume_req = 0; abs_req = 0;
        abs_write = 0; progbuf_req = 0;

        run_instr(OP_IMM, 3'b101, 1'b0, 1, 0, nxt);    // SRAI
        run_instr(OP_LOAD, 3'b010, 1'b0, 0, 3, nxt);   // load, completion 3 cycles late
        run_instr(OP_BRANCH, 3'b000, 1'b1, 0, 0, nxt);
        run_instr(OP_BRANCH, 3'b001, 1'b0, 0, 0, nxt);

        // halt_req raised while a store waits: store completes, then HALTED.
        fetch_phase(0);
        exec_phase(OP_STORE, 3'b010, 1'b0, nxt);
        halt_req = 1;
        mem_phase(1'b1, 2);
        halt_req = 0;
        halted_cycle("halted_after_store");

        // Abstract command, then resume winning over abs_req.
        abs_req = 1; abs_write = 1;
        halted_cycle("halted_absreq");
        abs_req = 0;
        #1; clr_exp(); e_halted = 1; e_aw = 1; e_ad = 1; check("abstract_write");
        tick();
        abs_write = 0;
        halted_cycle("halted_after_abs");
        abs_req = 1;
        halted_cycle("halted_absreq_rd");
        abs_req = 0;
        #1; clr_exp(); e_halted = 1; e_ad = 1; check("abstract_read");
        tick();
        resume_req = 1; abs_req = 1;
        halted_cycle("halted_resume");
        resume_req = 0; abs_req = 0;

        random_run(40);
        bad_op = 7'($urandom_range(0, 127)) & 7'b1111100;
        fetch_phase(1);
        exec_phase(bad_op, 3'($urandom_range(0, 7)), 1'b0, nxt);
        halted_cycle("halted_illegal");

        // Program-buffer run ending in EBREAK, with halt/resume requests ignored.
        progbuf_req = 1;
        halted_cycle("halted_pbreq");
        progbuf_req = 0; pb_mode = 1; halt_req = 1; resume_req = 1;
        random_run(8);
        fetch_phase(1);
        exec_phase(OP_SYSTEM, 3'b000, 1'b0, nxt);
        halt_req = 0; resume_req = 0;
        halted_cycle("halted_after_pb");
        halted_cycle("halted_idle");

        // Reset mid-access during a progbuf run.
        progbuf_req = 1;
        halted_cycle("halted_pbreq2");
        progbuf_req = 0; pb_mode = 1;
        fetch_phase(1);
        exec_phase(OP_LOAD, 3'b010, 1'b0, nxt);
        mem_complete = 0;
        #1; clr_exp(); e_in2 = 2'b01; e_mrd = 1; check("mem_wait_pre_rst");
        tick();
        rst = 1; mem_complete = 1; pb_mode = 0;
        #1; clr_exp(); check("rst_mid_access");
        tick();
        clr_exp(); check("rst_held");
        rst = 0; mem_complete = 0;
        fetch_phase(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
